// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM state type and counter-width helper for the button debouncer
package btn_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_PRESSED, ST_HELD} btn_state_e;
  function automatic int cnt_w(input int max_v);
    return (max_v < 1) ? 1 : $clog2(max_v + 1);
  endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one button's synchronizer, debouncer and press/long/repeat FSM
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int REPEAT_EN   = 1,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic clk_1khz,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);
  localparam int DW = cnt_w(DEBOUNCE_MS - 1);
  localparam int HW = cnt_w(((LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS) - 1);
  localparam logic [DW-1:0] DB_TC   = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] LONG_TC = HW'(LONG_MS - 1);
  localparam logic [HW-1:0] REP_TC  = HW'(REPEAT_MS - 1);
  logic [1:0] sync;
  logic [DW-1:0] db_cnt;
  logic [HW-1:0] hold_cnt;
  btn_state_e state;
  logic btn_s, flip, press_ev, rel_ev, long_tc, rep_tc;
  assign btn_s    = sync[1] ^ (ACTIVE_LOW != 0);
  assign flip     = (btn_s != btn_level) && (db_cnt == DB_TC);
  assign press_ev = flip && btn_s;
  assign rel_ev   = flip && !btn_s;
  assign long_tc  = (state == ST_PRESSED) && (hold_cnt == LONG_TC);
  assign rep_tc   = (state == ST_HELD) && (REPEAT_EN != 0) && (hold_cnt == REP_TC);
  // A release on a terminal-count edge wins: only release_pulse is reported.
  always_ff @(posedge clk_1khz)
    if (rst) begin
      sync          <= '0;
      db_cnt        <= '0;
      hold_cnt      <= '0;
      state         <= ST_IDLE;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      sync          <= {sync[0], btn_in};
      db_cnt        <= (btn_s == btn_level || flip) ? '0 : db_cnt + 1'b1;
      btn_level     <= flip ? btn_s : btn_level;
      press_pulse   <= press_ev;
      release_pulse <= rel_ev;
      long_pulse    <= long_tc && !rel_ev;
      repeat_pulse  <= rep_tc && !rel_ev;
      state         <= rel_ev ? ST_IDLE : press_ev ? ST_PRESSED : long_tc ? ST_HELD : state;
      hold_cnt      <= (press_ev || long_tc || rep_tc) ? '0 :
                       (state == ST_PRESSED || (state == ST_HELD && REPEAT_EN != 0)) ? hold_cnt + 1'b1 : hold_cnt;
    end
endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N_CH independent debounced buttons with press/release/long/repeat pulses
module btn_debounce_multi #(
  parameter int N_CH        = 4,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200,
  parameter int REPEAT_EN   = 1,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic            clk_1khz,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_pulse,
  output logic [N_CH-1:0] repeat_pulse
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .LONG_MS    (LONG_MS),
      .REPEAT_MS  (REPEAT_MS),
      .REPEAT_EN  (REPEAT_EN),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk_1khz     (clk_1khz),
      .rst          (rst),
      .btn_in       (btn_in[i]),
      .btn_level    (btn_level[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi: event-level model of both polarities plus directed scenario checks
module tb_btn_debounce_multi;
  localparam int DB = 20, LG = 1000, RP = 200;
  logic clk_1khz = 1'b0;
  logic rst;
  logic [4:0] btn;
  logic [3:0] a_lvl, a_prs, a_rel, a_lng, a_rep;
  logic b_lvl, b_prs, b_rel, b_lng, b_rep;
  int vectors = 0, miscompares = 0;
  bit started = 0;
  int edge_n = 0;
  always #5 clk_1khz = ~clk_1khz;

  btn_debounce_multi #(.N_CH(4)) dut_a (
    .clk_1khz(clk_1khz), .rst(rst), .btn_in(btn[3:0]), .btn_level(a_lvl),
    .press_pulse(a_prs), .release_pulse(a_rel), .long_pulse(a_lng), .repeat_pulse(a_rep)
  );
  btn_debounce_multi #(.N_CH(1), .ACTIVE_LOW(1)) dut_b (
    .clk_1khz(clk_1khz), .rst(rst), .btn_in(btn[4]), .btn_level(b_lvl),
    .press_pulse(b_prs), .release_pulse(b_rel), .long_pulse(b_lng), .repeat_pulse(b_rep)
  );

  // Model: bits 0..3 are active-high channels, bit 4 is the active-low instance.
  logic [4:0] e_lvl, e_prs, e_rel, e_lng, e_rep;
  logic [DB+1:0] hist [5];
  int hv [5];
  int pe [5];
  int m_d;
  logic m_pol;
  always @(posedge clk_1khz) begin
    edge_n++;
    for (int c = 0; c < 5; c++) begin
      m_pol = (c == 4);
      e_prs[c] = 1'b0; e_rel[c] = 1'b0; e_lng[c] = 1'b0; e_rep[c] = 1'b0;
      if (rst) begin
        hist[c] = {(DB+2){m_pol}};
        hv[c] = 2;
        e_lvl[c] = 1'b0;
      end else begin
        hist[c] = {hist[c][DB:0], btn[c] ^ m_pol};
        hv[c]++;
        if (hv[c] >= DB + 2 && hist[c][DB+1:2] == {DB{~e_lvl[c]}}) begin
          e_lvl[c] = ~e_lvl[c];
          e_prs[c] = e_lvl[c];
          e_rel[c] = ~e_lvl[c];
          pe[c] = edge_n;
        end else if (e_lvl[c]) begin
          m_d = edge_n - pe[c];
          e_lng[c] = (m_d == LG);
          e_rep[c] = (m_d > LG) && ((m_d - LG) % RP == 0);
        end
      end
    end
  end

  int press_cnt [5], press_at [5], rel_cnt [5], rel_at [5];
  int long_cnt [5], long_at [5], rep_cnt [5], rep_first [5], rep_last [5];
  int conc_hits = 0;
  logic [24:0] act, expv;
  always @(negedge clk_1khz) if (started) begin
    act  = {b_lvl, a_lvl, b_prs, a_prs, b_rel, a_rel, b_lng, a_lng, b_rep, a_rep};
    expv = {e_lvl, e_prs, e_rel, e_lng, e_rep};
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL cycle edge %0d: got lvl/prs/rel/lng/rep=%b_%b_%b_%b_%b want %b_%b_%b_%b_%b", edge_n,
               act[24:20], act[19:15], act[14:10], act[9:5], act[4:0],
               expv[24:20], expv[19:15], expv[14:10], expv[9:5], expv[4:0]);
    end
    if (a_prs == 4'b1001) conc_hits++;
    for (int c = 0; c < 5; c++) begin
      if (act[15+c]) begin press_cnt[c]++; press_at[c] = edge_n; end
      if (act[10+c]) begin rel_cnt[c]++; rel_at[c] = edge_n; end
      if (act[5+c]) begin long_cnt[c]++; long_at[c] = edge_n; end
      if (act[c]) begin
        if (rep_cnt[c] == 0) rep_first[c] = edge_n;
        rep_cnt[c]++;
        rep_last[c] = edge_n;
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_1khz);
  endtask

  int k, k2, e;
  initial begin
    rst = 1'b1;
    btn = 5'b10000;
    step(3);
    started = 1;
    check("reset_outputs", int'({a_lvl, a_prs, a_rel, a_lng, a_rep, b_lvl, b_prs, b_rel, b_lng, b_rep}), 0);
    rst = 1'b0;
    step(30);
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~i[0];
      btn[4] = i[0];
      step(5);
    end
    btn[0] = 1'b1;
    btn[4] = 1'b0;
    k = edge_n + 1;
    step(40);
    check("bounce_rise_edge", press_at[0], k + 21);
    check("bounce_press_count", press_cnt[0], 1);
    check("pol_level", int'(b_lvl), 1);
    check("pol_rise_edge", press_at[4], k + 21);
    check("pol_press_count", press_cnt[4], 1);
    btn[0] = 1'b0;
    btn[4] = 1'b1;
    step(30);
    btn[1] = 1'b1;
    step(10);
    btn[1] = 1'b0;
    step(40);
    check("glitch_press_count", press_cnt[1], 0);
    check("glitch_levels", int'(a_lvl), 0);
    btn[2] = 1'b1;
    k = edge_n + 1;
    step(1500);
    btn[2] = 1'b0;
    k2 = edge_n + 1;
    step(40);
    check("long_edge", long_at[2], k + 21 + 1000);
    check("repeat_first", rep_first[2], k + 21 + 1200);
    check("repeat_last", rep_last[2], k + 21 + 1400);
    check("repeat_count", rep_cnt[2], 2);
    check("hold_release_edge", rel_at[2], k2 + 21);
    check("hold_release_count", rel_cnt[2], 1);
    btn[0] = 1'b1;
    btn[3] = 1'b1;
    step(40);
    check("concurrent_press", conc_hits, 1);
    btn[0] = 1'b0;
    btn[3] = 1'b0;
    step(40);
    btn[1] = 1'b1;
    k = edge_n + 1;
    while (edge_n < k + 21 + 500) step(1);
    check("pre_reset_level", int'(a_lvl[1]), 1);
    rst = 1'b1;
    step(1);
    check("mid_hold_reset_outputs", int'({a_lvl, a_prs, a_rel, a_lng, a_rep}), 0);
    rst = 1'b0;
    e = edge_n + 1;
    step(700);
    check("no_long_after_reset", long_cnt[1], 0);
    check("re_press_edge", press_at[1], e + 21);
    check("re_press_count", press_cnt[1], 2);
    btn[1] = 1'b0;
    step(40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
